// File: rtl/pause_dim_ctl.sv
// Pause and screen-dim controller: merges user/external/OSD pause sources into one
// CPU pause (optionally vblank-aligned) and dims the RGB stream after a pause timeout.
module pause_dim_ctl #(
    parameter int RW            = 3,
    parameter int GW            = 3,
    parameter int BW            = 2,
    parameter int NREQ          = 1,
    parameter int TICKS_PER_SEC = 24000000,
    parameter int DIM_SECONDS   = 10,
    parameter int DIM_SHIFT     = 1,
    parameter bit ALIGN_VBLANK  = 1'b1
) (
    input  logic                  clk_sys,
    input  logic                  reset,
    input  logic                  user_button,
    input  logic [NREQ-1:0]       pause_request,
    input  logic [1:0]            options,
    input  logic                  OSD_STATUS,
    input  logic                  vblank,
    input  logic [RW-1:0]         r,
    input  logic [GW-1:0]         g,
    input  logic [BW-1:0]         b,
    output logic [RW+GW+BW-1:0]   rgb_out,
    output logic                  pause_cpu,
    output logic                  dim_active
);

    typedef enum logic [1:0] {RUN, PEND_PAUSE, PAUSED, PEND_RUN} state_e;

    localparam int            PW        = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int            SW        = 8;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_SEC - 1);
    localparam logic [SW-1:0] SEC_MAX   = SW'(DIM_SECONDS);
    localparam bit            DIM_EN    = (DIM_SHIFT != 0);

    state_e                 state_q, state_d;
    logic                   btn_q, vblank_q, user_pause_q, want_q;
    logic                   user_pause_d, want_d, btn_rise, vblank_rise;
    logic [PW-1:0]          presc_q, presc_d;
    logic [SW-1:0]          sec_q, sec_d;
    logic                   dim_q, dim_d, paused_d;
    logic [RW+GW+BW-1:0]    rgb_q, rgb_d;

    // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        btn_rise     = user_button & ~btn_q;
        vblank_rise  = vblank & ~vblank_q;
        user_pause_d = user_pause_q ^ btn_rise;
        want_d       = user_pause_d | (|pause_request) | (options[0] & OSD_STATUS);
    end

    // Next-state logic; the FSM acts on the registered want.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:        if (want_q)  state_d = ALIGN_VBLANK ? PEND_PAUSE : PAUSED;
            PEND_PAUSE: if (!want_q) state_d = RUN;
                        else if (vblank_rise) state_d = PAUSED;
            PAUSED:     if (!want_q) state_d = ALIGN_VBLANK ? PEND_RUN : RUN;
            PEND_RUN:   if (want_q)  state_d = PAUSED;
                        else if (vblank_rise) state_d = RUN;
            default:    state_d = RUN;
        endcase
    end

    // Output decode of the state register.
    always_comb begin
        pause_cpu = (state_q == PAUSED) || (state_q == PEND_RUN);
        paused_d  = (state_d == PAUSED) || (state_d == PEND_RUN);
    end

    // Dim timer and registered video path; dim is computed from next-state values so
    // dim_active and the dimmed pixels appear on the same cycle.
    always_comb begin
        presc_d = '0;
        sec_d   = '0;
        if (pause_cpu) begin
            if (presc_q == PRESC_MAX) begin
                sec_d = (sec_q == SEC_MAX) ? sec_q : sec_q + 1'b1;
            end else begin
                presc_d = presc_q + 1'b1;
                sec_d   = sec_q;
            end
        end
        dim_d = options[1] & paused_d & (sec_d == SEC_MAX) & DIM_EN;
        rgb_d = dim_d ? {r >> DIM_SHIFT, g >> DIM_SHIFT, b >> DIM_SHIFT} : {r, g, b};
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            // NOTE: button history loads the live button so one held through reset is not a new press.
            btn_q        <= user_button;
            vblank_q     <= 1'b0;
            user_pause_q <= 1'b0;
            want_q       <= 1'b0;
            state_q      <= RUN;
            presc_q      <= '0;
            sec_q        <= '0;
            dim_q        <= 1'b0;
            rgb_q        <= '0;
        end else begin
            btn_q        <= user_button;
            vblank_q     <= vblank;
            user_pause_q <= user_pause_d;
            want_q       <= want_d;
            state_q      <= state_d;
            presc_q      <= presc_d;
            sec_q        <= sec_d;
            dim_q        <= dim_d;
            rgb_q        <= rgb_d;
        end
    end

    assign dim_active = dim_q;
    assign rgb_out    = rgb_q;

endmodule

// File: tb/tb_pause_dim_ctl.sv
// Bench for pause_dim_ctl: an unaligned and an aligned instance share stimulus and are
// compared every cycle against a behavioural model, plus table and directed sequences.
module tb_pause_dim_ctl;

    localparam int T = 10;
    localparam int D = 2;

    logic       clk = 1'b0;
    logic       reset, user_button, osd, vblank;
    logic [1:0] pause_request, options;
    logic [2:0] r, g;
    logic [1:0] b;
    logic [7:0] rgb_u, rgb_a;
    logic       pc_u, pc_a, dim_u, dim_a;

    always #5 clk = ~clk;

    pause_dim_ctl #(.RW(3), .GW(3), .BW(2), .NREQ(2), .TICKS_PER_SEC(T), .DIM_SECONDS(D),
                    .DIM_SHIFT(1), .ALIGN_VBLANK(1'b0)) u_una (
        .clk_sys(clk), .reset(reset), .user_button(user_button), .pause_request(pause_request),
        .options(options), .OSD_STATUS(osd), .vblank(vblank), .r(r), .g(g), .b(b),
        .rgb_out(rgb_u), .pause_cpu(pc_u), .dim_active(dim_u));

    pause_dim_ctl #(.RW(3), .GW(3), .BW(2), .NREQ(2), .TICKS_PER_SEC(T), .DIM_SECONDS(D),
                    .DIM_SHIFT(1), .ALIGN_VBLANK(1'b1)) u_aln (
        .clk_sys(clk), .reset(reset), .user_button(user_button), .pause_request(pause_request),
        .options(options), .OSD_STATUS(osd), .vblank(vblank), .r(r), .g(g), .b(b),
        .rgb_out(rgb_a), .pause_cpu(pc_a), .dim_active(dim_a));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model. Index 0 = unaligned instance, 1 = aligned instance.
    bit       m_up, m_btn_prev, m_vb_prev, m_want;
    bit       m_paused [2];
    bit       m_seen   [2];
    int       m_cnt    [2];
    bit       m_dim    [2];
    int       m_rgb    [2];

    function automatic int pix(input bit dim);
        int rr, gg, bb;
        rr = dim ? int'(r) / 2 : int'(r);
        gg = dim ? int'(g) / 2 : int'(g);
        bb = dim ? int'(b) / 2 : int'(b);
        return rr * 32 + gg * 4 + bb;
    endfunction

    task automatic model_update();
        bit vrise, up_n, want_n, pn;
        if (reset) begin
            m_up = 0; m_btn_prev = user_button; m_vb_prev = 0; m_want = 0;
            for (int i = 0; i < 2; i++) begin
                m_paused[i] = 0; m_seen[i] = 0; m_cnt[i] = 0; m_dim[i] = 0; m_rgb[i] = 0;
            end
            return;
        end
        vrise  = vblank && !m_vb_prev;
        up_n   = m_up ^ (user_button && !m_btn_prev);
        want_n = up_n || (pause_request != 0) || (options[0] && osd);
        for (int i = 0; i < 2; i++) begin
            if (i == 0) pn = m_want;
            // Aligned: a change lands on a vblank rise, if it was already requested a cycle earlier.
            else pn = (vrise && m_want != m_paused[i] && m_seen[i] != m_paused[i]) ? m_want : m_paused[i];
            m_seen[i]   = m_want;
            m_cnt[i]    = m_paused[i] ? m_cnt[i] + 1 : 0;
            m_dim[i]    = options[1] && pn && (m_cnt[i] >= D * T);
            m_rgb[i]    = pix(m_dim[i]);
            m_paused[i] = pn;
        end
        m_up = up_n; m_want = want_n; m_btn_prev = user_button; m_vb_prev = vblank;
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        check("pause_una", pc_u,  m_paused[0]);
        check("dim_una",   dim_u, m_dim[0]);
        check("rgb_una",   rgb_u, m_rgb[0]);
        check("pause_aln", pc_a,  m_paused[1]);
        check("dim_aln",   dim_a, m_dim[1]);
        check("rgb_aln",   rgb_a, m_rgb[1]);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    typedef struct {
        bit         btn;
        logic [1:0] req;
        logic [1:0] opt;
        logic [2:0] rr, gg;
        logic [1:0] bb;
        bit         exp_pc;
        bit         exp_dim;
        logic [7:0] exp_rgb;
    } vec_t;

    vec_t tbl [4];

    initial begin
        tbl[0] = '{0, 2'b00, 2'b10, 3'd7, 3'd6, 2'd3, 0, 0, 8'hFB};
        tbl[1] = '{1, 2'b00, 2'b10, 3'd7, 3'd6, 2'd3, 0, 0, 8'hFB};
        tbl[2] = '{0, 2'b00, 2'b10, 3'd7, 3'd6, 2'd3, 1, 0, 8'hFB};
        tbl[3] = '{0, 2'b00, 2'b10, 3'd7, 3'd6, 2'd3, 1, 0, 8'hFB};

        reset = 1'b1; user_button = 0; pause_request = 0; options = 0; osd = 0; vblank = 0;
        r = 0; g = 0; b = 0;
        do_reset();
        check("reset_pc",  pc_u,  1'b0);
        check("reset_dim", dim_u, 1'b0);
        check("reset_rgb", rgb_u, 8'h00);

        // Unaligned button pause, table driven.
        for (int i = 0; i < 4; i++) begin
            user_button = tbl[i].btn; pause_request = tbl[i].req; options = tbl[i].opt;
            r = tbl[i].rr; g = tbl[i].gg; b = tbl[i].bb;
            step();
            check($sformatf("tbl%0d_pc", i),  pc_u,  tbl[i].exp_pc);
            check($sformatf("tbl%0d_dim", i), dim_u, tbl[i].exp_dim);
            check($sformatf("tbl%0d_rgb", i), rgb_u, tbl[i].exp_rgb);
        end
        for (int i = 0; i < 18; i++) step();
        check("dim_early", dim_u, 1'b0);
        step();
        check("dim_on",   dim_u, 1'b1);
        check("rgb_dim",  rgb_u, 8'h6D);

        options = 2'b00; step();
        check("dim_opt_off", dim_u, 1'b0);
        check("rgb_opt_off", rgb_u, 8'hFB);
        options = 2'b10; step();
        check("dim_opt_on",  dim_u, 1'b1);

        user_button = 1; step();
        check("unpause_hold", pc_u, 1'b1);
        user_button = 0; step();
        check("unpause_pc",  pc_u,  1'b0);
        check("unpause_rgb", rgb_u, 8'hFB);

        // Dim again, then reset with the button held.
        user_button = 1; step();
        user_button = 0; step();
        for (int i = 0; i < 20; i++) step();
        check("redim", dim_u, 1'b1);
        user_button = 1; reset = 1; step();
        check("rst_pc",  pc_u,  1'b0);
        check("rst_dim", dim_u, 1'b0);
        check("rst_rgb", rgb_u, 8'h00);
        reset = 0; step();
        check("post_rst_rgb", rgb_u, 8'hFB);
        for (int i = 0; i < 3; i++) step();
        check("held_no_toggle", pc_u, 1'b0);
        user_button = 0; step();

        // Aligned: request mid-frame, pause waits for vblank rise.
        options = 2'b00; pause_request = 2'b01;
        for (int i = 0; i < 5; i++) step();
        check("aln_wait",  pc_a, 1'b0);
        check("una_fast",  pc_u, 1'b1);
        vblank = 1; step();
        check("aln_on",    pc_a, 1'b1);
        vblank = 0; for (int i = 0; i < 3; i++) step();
        pause_request = 2'b00;
        for (int i = 0; i < 5; i++) step();
        check("aln_hold",  pc_a, 1'b1);
        vblank = 1; step();
        check("aln_off",   pc_a, 1'b0);

        // Glitch between vblanks never reaches the aligned CPU pause.
        vblank = 0; step();
        pause_request = 2'b01;
        for (int i = 0; i < 5; i++) begin step(); check("glitch_pc", pc_a, 1'b0); end
        pause_request = 2'b00;
        for (int i = 0; i < 5; i++) begin step(); check("glitch_pc", pc_a, 1'b0); end
        vblank = 1; step();
        check("glitch_vb", pc_a, 1'b0);
        vblank = 0;

        // OSD pause with dimming disabled.
        options = 2'b01; osd = 1; step(); step();
        check("osd_pause", pc_u, 1'b1);
        for (int i = 0; i < 100; i++) step();
        check("osd_nodim", dim_u, 1'b0);
        options = 2'b00; step(); step();
        check("osd_release", pc_u, 1'b0);
        osd = 0;

        // Overlap of user latch and external request.
        user_button = 1; step(); user_button = 0; step();
        check("ovl_user_on", pc_u, 1'b1);
        pause_request = 2'b10; step();
        user_button = 1; step(); user_button = 0; step(); step();
        check("ovl_held", pc_u, 1'b1);
        pause_request = 2'b00; step(); step();
        check("ovl_release", pc_u, 1'b0);

        // Randomized run against the model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0)   user_button = ~user_button;
            if ($urandom_range(0, 40) == 0)  pause_request[0] = ~pause_request[0];
            if ($urandom_range(0, 40) == 0)  pause_request[1] = ~pause_request[1];
            if ($urandom_range(0, 60) == 0)  options = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 30) == 0)  osd = ~osd;
            if ($urandom_range(0, 12) == 0)  vblank = ~vblank;
            reset = ($urandom_range(0, 499) == 0);
            r = 3'($urandom); g = 3'($urandom); b = 2'($urandom);
            step();
        end
        reset = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
